// File: rtl/key_filter.sv
// rtl/key_filter.sv - per-channel key synchronizer, debouncer and hold/auto-repeat detector
module key_filter #(
  parameter int N           = 4,
  parameter int DB_CYCLES   = 480000,
  parameter int LONG_CYCLES = 24000000,
  parameter int REP_CYCLES  = 4800000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key_raw,
  output logic [N-1:0] key_level,
  output logic [N-1:0] key_press,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_rep
);

  localparam int HMAX = (LONG_CYCLES > REP_CYCLES) ? LONG_CYCLES : REP_CYCLES;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int DW   = $clog2(DB_CYCLES);

  localparam logic            RELEASED  = (ACTIVE_LOW != 0);
  localparam logic [DW-1:0]   DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [HW-1:0]   LONG_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0]   REP_LAST  = (REP_CYCLES == 0) ? '0 : HW'(REP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_e;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [1:0]    sync;
    logic          pressed_now;
    logic [DW-1:0] db_cnt;
    logic          level_q, press_q, release_q, long_q, rep_q;
    logic          flip, press_ev, release_ev;
    hold_state_e   state, state_nx;
    logic [HW-1:0] hold_cnt, hold_cnt_nx;
    logic          long_nx, rep_nx;

    // Synchronizer resets to the released level so a key held through reset reads as a new press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= {2{RELEASED}};
      else        sync <= {sync[0], key_raw[i]};
    end

    assign pressed_now = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
    assign flip        = (pressed_now != level_q) && (db_cnt == DB_LAST);
    assign press_ev    = flip & ~level_q;
    assign release_ev  = flip & level_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= press_ev;
        release_q <= release_ev;
        if (pressed_now == level_q) begin
          db_cnt <= '0;
        end else if (flip) begin
          db_cnt  <= '0;
          level_q <= ~level_q;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        hold_cnt <= '0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
      end else begin
        state    <= state_nx;
        hold_cnt <= hold_cnt_nx;
        long_q   <= long_nx;
        rep_q    <= rep_nx;
      end
    end

    // Release wins over long/repeat so no pulse can coincide with or follow key_release.
    always_comb begin
      state_nx    = state;
      hold_cnt_nx = hold_cnt;
      long_nx     = 1'b0;
      rep_nx      = 1'b0;
      case (state)
        IDLE: begin
          hold_cnt_nx = '0;
          if (press_ev) state_nx = HELD;
        end
        HELD: begin
          if (release_ev) begin
            state_nx    = IDLE;
            hold_cnt_nx = '0;
          end else if (hold_cnt == LONG_LAST) begin
            state_nx    = LONG;
            hold_cnt_nx = '0;
            long_nx     = 1'b1;
          end else begin
            hold_cnt_nx = hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (release_ev) begin
            state_nx    = IDLE;
            hold_cnt_nx = '0;
          end else if (REP_CYCLES != 0) begin
            if (hold_cnt == REP_LAST) begin
              hold_cnt_nx = '0;
              rep_nx      = 1'b1;
            end else begin
              hold_cnt_nx = hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_nx    = IDLE;
          hold_cnt_nx = '0;
        end
      endcase
    end

    assign key_level[i]   = level_q;
    assign key_press[i]   = press_q;
    assign key_release[i] = release_q;
    assign key_long[i]    = long_q;
    assign key_rep[i]     = rep_q;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 SHALL have parameter N, default 4, number of independent key channels (1..32).
REQ-002 SHALL have parameter DB_CYCLES, default 480000, consecutive stable cycles required to accept a level change (>=2).
REQ-003 SHALL have parameter LONG_CYCLES, default 24000000, cycles a debounced press must be held before key_long fires (>DB_CYCLES).
REQ-004 SHALL have parameter REP_CYCLES, default 4800000, auto-repeat period after key_long; 0 disables repeat.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1, 1 = raw key reads 0 when pressed.
REQ-006 SHALL have port clk input 1, system clock.
REQ-007 SHALL have port rst_n input 1, reset, asynchronous, active-low.
REQ-008 SHALL have port key_raw input N, asynchronous raw key pins.
REQ-009 SHALL have port key_level output N, debounced state, 1 = pressed, regardless of ACTIVE_LOW.
REQ-010 SHALL have port key_press output N, one-cycle pulse on debounced press.
REQ-011 SHALL have port key_release output N, one-cycle pulse on debounced release.
REQ-012 SHALL have port key_long output N, one-cycle pulse when the hold reaches LONG_CYCLES.
REQ-013 SHALL have port key_rep output N, one-cycle auto-repeat pulse.

Function
REQ-014 Each channel SHALL pass key_raw through a 2-flop synchronizer, then normalise polarity so 1 = pressed.
REQ-015 Each channel SHALL own a debounce counter of width $clog2(DB_CYCLES); no counters shared between channels.
REQ-016 Counter SHALL clear in any cycle where the synchronized level equals key_level, and increment otherwise.
REQ-017 When the counter reaches DB_CYCLES-1 and the level still differs, the next edge SHALL flip key_level and clear the counter.
REQ-018 key_level SHALL therefore change exactly DB_CYCLES+2 cycles after key_raw settles; any bounce shorter than DB_CYCLES SHALL produce no output activity.
REQ-019 key_press/key_release SHALL be registered and asserted in the first cycle key_level shows its new value.
REQ-020 Each channel SHALL run a hold FSM with states IDLE, HELD, LONG.
REQ-021 Transitions SHALL be: IDLE->HELD on debounced press, hold counter cleared.
REQ-022 HELD->LONG when the hold counter reaches LONG_CYCLES-1, asserting key_long exactly LONG_CYCLES cycles after key_press.
REQ-023 In LONG with REP_CYCLES!=0, key_rep SHALL pulse every REP_CYCLES cycles, first pulse REP_CYCLES after key_long.
REQ-024 HELD or LONG -> IDLE on debounced release; hold/repeat counters SHALL clear; no key_long/key_rep in the release cycle or after.
REQ-025 Hold counter width SHALL be $clog2(max(LONG_CYCLES,REP_CYCLES)+1) and SHALL never wrap; LONG state SHALL persist indefinitely while held.
REQ-026 Release before LONG_CYCLES SHALL produce key_press and key_release only.
REQ-027 Simultaneous events on different channels SHALL be handled independently in the same cycle.

Reset
REQ-028 On rst_n low, all synchronizer flops SHALL load the released level, all counters SHALL be 0, all FSMs SHALL be IDLE, and all outputs SHALL be 0, asynchronously.
REQ-029 A key held through reset release SHALL be detected as a fresh press (key_press after DB_CYCLES+2 cycles), never a release.
REQ-030 Reset asserted mid-hold SHALL abort without emitting key_release.

Verification (N=2, DB_CYCLES=4, LONG_CYCLES=20, REP_CYCLES=8, ACTIVE_LOW=1)
REQ-031 ch0 raw toggles low 3 cycles / high 1 cycle repeatedly for 40 cycles -> key_level=0, no pulses.
REQ-032 ch0 raw driven low at cycle 0 and held -> key_level[0]=1 and key_press[0] at cycle 6; key_long[0] at 26; key_rep[0] at 34, 42, 50.
REQ-033 ch0 low at 0, high at 15 -> key_press at 6, key_release at 21, no key_long.
REQ-034 ch0 and ch1 both pressed at cycle 0 -> key_press=2'b11 at cycle 6; ch1 released at 10 -> key_release[1] at 16 while ch0 continues to key_long at 26.
REQ-035 ch0 held, rst_n pulsed low at cycle 30 for 2 cycles -> outputs 0 immediately, no key_release; key_press[0] 6 cycles after rst_n returns high.
REQ-036 REP_CYCLES=0 rerun of REQ-032 -> key_long at 26, key_rep never asserted.
